// File: rtl/polyunit_seq.sv
// Command sequencer for polyunit_core2: turns LOAD/NTT/INTT/DUMP commands into core mode/run pulses,
// streams load words into the core RAM, captures the timed dump burst and guards NTT/INTT with a timeout.
module polyunit_seq #(
    parameter int WID      = 12,
    parameter int WORDS    = 32,
    parameter int DOUT_LAT = 2,
    parameter int TIMEOUT  = 4095,
    localparam int DW      = 4 * WID,
    localparam int AW      = $clog2(WORDS),
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    output logic          cmd_ready,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic          err,
    output logic [1:0]    core_mode,
    output logic          core_run,
    output logic [DW-1:0] core_data_in,
    output logic [AW-1:0] core_data_in_add,
    output logic          core_data_in_done,
    input  logic [DW-1:0] core_data_out,
    input  logic          core_done,
    output logic [2:0]    o_dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_LDONE = 3'd3;
    localparam logic [2:0] S_XWAIT = 3'd4;
    localparam logic [2:0] S_DUMP  = 3'd5;

    localparam logic [1:0] OP_LOAD = 2'd2;
    localparam logic [1:0] OP_DUMP = 2'd3;

    logic [2:0]    r_state;
    logic [1:0]    r_mode;
    logic [AW-1:0] r_cnt;
    logic [TW-1:0] r_tmo;
    logic          r_err;
    logic          r_m_valid;
    logic          r_m_last;
    logic [DW-1:0] r_m_data;
    logic [DW-1:0] r_din;
    logic [AW-1:0] r_din_add;

    logic          w_last;
    logic          w_capture;
    logic [AW-1:0] w_cnt_next;

    // Handshakes: a transfer happens on a rising edge where valid && ready; cmd_ready/s_ready depend only on
    // state, never on the partner's valid. The m_ side has no ready: a beat is every cycle m_valid is high.
    assign w_last     = (r_cnt == AW'(WORDS - 1));
    assign w_cnt_next = w_last ? '0 : r_cnt + AW'(1);
    // r_tmo counts cycles since the run pulse, so it also times the core's dump latency (DOUT_LAT >= 1).
    assign w_capture  = (r_state == S_DUMP) && (r_tmo >= TW'(DOUT_LAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'd0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_din     <= '0;
            r_din_add <= '0;
        end else begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_mode  <= cmd_op;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_tmo   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_tmo <= r_tmo + TW'(1);
                    case (r_mode)
                        OP_LOAD: r_state <= S_LOAD;
                        OP_DUMP: r_state <= S_DUMP;
                        default: r_state <= S_XWAIT;
                    endcase
                end
                S_LOAD: begin
                    if (s_valid) begin
                        r_din     <= s_data;
                        r_din_add <= r_cnt;
                        r_cnt     <= w_cnt_next;
                        if (w_last) r_state <= S_LDONE;
                    end
                end
                S_LDONE: begin
                    r_mode  <= 2'd0;
                    r_state <= S_IDLE;
                end
                S_XWAIT: begin
                    // A done arriving on the timeout cycle wins, so err is only set when done is absent.
                    if (core_done) begin
                        r_mode  <= 2'd0;
                        r_state <= S_IDLE;
                    end else if (r_tmo == TW'(TIMEOUT)) begin
                        r_err   <= 1'b1;
                        r_mode  <= 2'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_DUMP: begin
                    if (w_capture) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= core_data_out;
                        r_m_last  <= w_last;
                        r_cnt     <= w_cnt_next;
                        if (w_last) begin
                            r_mode  <= 2'd0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: begin
                    r_mode  <= 2'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready         = (r_state == S_IDLE);
    assign s_ready           = (r_state == S_LOAD);
    assign busy              = (r_state != S_IDLE);
    assign core_run          = (r_state == S_RUN);
    assign core_data_in_done = (r_state == S_LDONE);
    assign core_mode         = r_mode;
    assign core_data_in      = r_din;
    assign core_data_in_add  = r_din_add;
    assign err               = r_err;
    assign m_valid           = r_m_valid;
    assign m_data            = r_m_data;
    assign m_last            = r_m_last;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_polyunit_seq.sv
// Directed bench for polyunit_seq: load streams, NTT/INTT done and timeout, dump burst timing, reset abort.
module tb_polyunit_seq;

    localparam int WID      = 12;
    localparam int WORDS    = 32;
    localparam int DOUT_LAT = 2;
    localparam int TIMEOUT  = 4095;
    localparam int DW       = 4 * WID;
    localparam int AW       = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic          cmd_ready;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          err;
    logic [1:0]    core_mode;
    logic          core_run;
    logic [DW-1:0] core_data_in;
    logic [AW-1:0] core_data_in_add;
    logic          core_data_in_done;
    logic [DW-1:0] core_data_out;
    logic          core_done;
    logic [2:0]    o_dbg_state;

    polyunit_seq #(.WID(WID), .WORDS(WORDS), .DOUT_LAT(DOUT_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err),
        .core_mode(core_mode), .core_run(core_run),
        .core_data_in(core_data_in), .core_data_in_add(core_data_in_add),
        .core_data_in_done(core_data_in_done),
        .core_data_out(core_data_out), .core_done(core_done),
        .o_dbg_state(o_dbg_state)
    );

    // ---- clock / cycle count ----
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_done = 0;
    always @(negedge clk) if (core_data_in_done) n_done <= n_done + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 100000", cyc);
        $fatal(1, "watchdog");
    end

    // ---- scoreboard ----
    logic [63:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int run_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        check({tag, "_q_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] op);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        run_cyc   = cyc;
        check("run_pulse", 64'(core_run), 64'd1);
        check("run_mode", 64'(core_mode), 64'(op));
        check("err_clear_on_accept", 64'(err), 64'd0);
        check("busy_run", 64'(busy), 64'd1);
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        tick();
        check("run_one_cycle", 64'(core_run), 64'd0);
        check("mode_hold", 64'(core_mode), 64'(op));
    endtask

    // Drives n beats (optionally with a one-cycle gap after each) and checks address/data per beat.
    task automatic load_beats(input int n, input bit gaps, input bit random_data);
        int b = 0;
        int k = 0;
        bit v;
        while (b < n) begin
            v = gaps ? (k % 2 == 0) : 1'b1;
            s_valid = v;
            s_data  = random_data ? DW'({$urandom, $urandom}) : DW'(b);
            check("s_ready_load", 64'(s_ready), 64'd1);
            if (v) exp_q.push_back({11'd0, AW'(b), s_data});
            tick();
            if (v) begin
                pop_check("load_word", {11'd0, core_data_in_add, core_data_in});
                check("load_done_strobe", 64'(core_data_in_done), 64'(b == WORDS - 1));
                b++;
            end else begin
                check("load_addr_hold", 64'(core_data_in_add), 64'(b - 1));
            end
            k++;
        end
        s_valid = 1'b0;
    endtask

    int d0;
    int beats;
    int first_beat;
    int j;

    // ---- directed sequence ----
    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; s_valid = 1'b0; s_data = '0;
        core_data_out = '0; core_done = 1'b0;

        // 1: reset
        repeat (10) tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_core_run", 64'(core_run), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(o_dbg_state), 64'd0);
        rst = 1'b0;
        tick();

        // s_valid outside LOAD is not consumed
        s_valid = 1'b1; s_data = DW'(48'hABCDEF123456);
        tick();
        check("idle_s_ready", 64'(s_ready), 64'd0);
        check("idle_no_write", {11'd0, core_data_in_add, core_data_in}, 64'd0);
        s_valid = 1'b0;

        // 2: continuous LOAD, data = index
        d0 = n_done;
        start_cmd(2'd2);
        load_beats(WORDS, 1'b0, 1'b0);
        tick();
        check("load_done_once", 64'(n_done - d0), 64'd1);
        check("load_idle_after", 64'(cmd_ready), 64'd1);
        check("load_mode_cleared", 64'(core_mode), 64'd0);

        // 3: LOAD with gaps, core_done held high to show it is ignored outside XWAIT
        d0 = n_done;
        start_cmd(2'd2);
        core_done = 1'b1;
        load_beats(WORDS, 1'b1, 1'b1);
        core_done = 1'b0;
        tick();
        check("gap_done_once", 64'(n_done - d0), 64'd1);
        check("gap_idle_after", 64'(busy), 64'd0);

        // 4a: NTT, done 100 cycles after run
        start_cmd(2'd0);
        while (cyc < run_cyc + 100) tick();
        check("ntt_busy_waiting", 64'(busy), 64'd1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("ntt_busy_fall", 64'(busy), 64'd0);
        check("ntt_err", 64'(err), 64'd0);
        check("ntt_mode_cleared", 64'(core_mode), 64'd0);

        // 4b: INTT without done -> timeout
        start_cmd(2'd1);
        while (cyc < run_cyc + TIMEOUT) tick();
        check("tmo_err_before", 64'(err), 64'd0);
        check("tmo_busy_before", 64'(busy), 64'd1);
        tick();
        check("tmo_err_set", 64'(err), 64'd1);
        check("tmo_busy_fall", 64'(busy), 64'd0);
        tick();
        check("tmo_err_sticky", 64'(err), 64'd1);

        // 4c: done on the timeout cycle counts as success (accept also clears the sticky err)
        start_cmd(2'd0);
        while (cyc < run_cyc + TIMEOUT) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("edge_done_err", 64'(err), 64'd0);
        check("edge_done_idle", 64'(busy), 64'd0);

        // 5: DUMP, core_data_out carries the word index from run+DOUT_LAT on
        start_cmd(2'd3);
        beats = 0;
        first_beat = -1;
        for (int n = 0; n < DOUT_LAT + WORDS + 3; n++) begin
            j = cyc - (run_cyc + DOUT_LAT);
            if (j >= 0 && j < WORDS) begin
                core_data_out = {4{12'(j)}};
                exp_q.push_back({15'd0, (j == WORDS - 1), core_data_out});
            end else begin
                core_data_out = DW'(48'hBADBADBADBAD);
            end
            tick();
            if (m_valid) begin
                if (beats == 0) first_beat = cyc;
                beats++;
                pop_check("dump_word", {15'd0, m_last, m_data});
            end
        end
        check("dump_beats", 64'(beats), 64'(WORDS));
        check("dump_first_beat", 64'(first_beat), 64'(run_cyc + DOUT_LAT + 1));
        check("dump_q_drained", 64'(exp_q.size()), 64'd0);
        check("dump_idle_after", 64'(busy), 64'd0);

        // 6: reset during load beat 17 aborts, next LOAD restarts at address 0
        d0 = n_done;
        start_cmd(2'd2);
        load_beats(17, 1'b0, 1'b1);
        s_valid = 1'b1; s_data = DW'(48'h111122223333);
        rst = 1'b1;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        check("abort_idle", 64'(cmd_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_addr", 64'(core_data_in_add), 64'd0);
        check("abort_mode", 64'(core_mode), 64'd0);
        repeat (3) tick();
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        start_cmd(2'd2);
        load_beats(WORDS, 1'b0, 1'b1);
        tick();
        check("restart_done_once", 64'(n_done - d0), 64'd1);
        check("restart_idle", 64'(cmd_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
